// File: rtl/cla_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cla_seq_ctrl
// Description : Nibble-serial add/subtract sequencer that pushes one 4-bit
//               carry-lookahead slice across the operands, one nibble per
//               enabled cycle, with a single-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_seq_ctrl #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             sub,
    input  logic             clr,
    input  logic [4*NIB-1:0] op_a,
    input  logic [4*NIB-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [4*NIB-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int W    = 4 * NIB;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);
    localparam logic [W-1:0]    NIB_MASK = W'(4'hF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [W-1:0]    a_q,      a_d;
    logic [W-1:0]    b_q,      b_d;
    logic            carry_q,  carry_d;
    logic [IDXW-1:0] idx_q,    idx_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q,   cout_d;
    logic            ovf_q,    ovf_d;

    // Operand nibble selected by the current index
    logic [IDXW+1:0] nib_pos;
    logic [W-1:0]    a_shift;
    logic [W-1:0]    b_shift;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;

    assign nib_pos = {idx_q, 2'b00};
    assign a_shift = a_q >> nib_pos;
    assign b_shift = b_q >> nib_pos;
    assign a_nib   = a_shift[3:0];
    assign b_nib   = b_shift[3:0];

    // The single 4-bit carry-lookahead slice, reused for every nibble
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    logic [3:0] slice_sum;

    assign p    = a_nib ^ b_nib;
    assign g    = a_nib & b_nib;
    assign c[0] = carry_q;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign slice_sum = p ^ c[3:0];

    logic [W-1:0] sum_placed;
    logic [W-1:0] mask_placed;

    assign sum_placed  = W'(slice_sum) << nib_pos;
    assign mask_placed = NIB_MASK << nib_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        if (ena) begin
            // Abort leaves the visible result untouched
            if (clr) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            a_d      = op_a;
                            b_d      = sub ? ~op_b : op_b;
                            carry_d  = sub;
                            idx_d    = '0;
                            result_d = '0;
                            cout_d   = 1'b0;
                            ovf_d    = 1'b0;
                            state_d  = S_RUN;
                        end
                    end
                    S_RUN: begin
                        result_d = (result_q & ~mask_placed) | sum_placed;
                        carry_d  = c[4];
                        if (idx_q == LAST_IDX) begin
                            cout_d  = c[4];
                            ovf_d   = c[3] ^ c[4];
                            state_d = S_DONE;
                        end else begin
                            idx_d = idx_q + IDXW'(1);
                        end
                    end
                    S_DONE: begin
                        state_d = S_IDLE;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy   = (state_q == S_RUN) || (state_q == S_DONE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_seq_ctrl
// Description : Self-checking bench for cla_seq_ctrl (NIB=4): directed table,
//               multi-cycle corner sequences and randomized operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;
    localparam int LAT = NIB + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic         sub;
    logic         clr;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    cla_seq_ctrl #(.NIB(NIB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .start  (start),
        .sub    (sub),
        .clr    (clr),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the integer definitions
    task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic co, output logic ov);
        logic [W:0] full;
        if (!s) begin
            full = {1'b0, a} + {1'b0, b};
            r    = full[W-1:0];
            co   = full[W];
            ov   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r  = a - b;
            co = (a >= b);
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
    endtask

    // One operation; sa/sl = ena-low window, ra = edge count before a stray start
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int sa, input int sl, input int ra,
                          output logic [W-1:0] r, output logic co, output logic ov,
                          output int lat, output int bc, output int dn);
        int t;
        t   = 0;
        lat = -1;
        bc  = 0;
        dn  = 0;
        sub = s;
        while (t < 60 && lat < 0) begin
            start = (t == 0) || (t == ra);
            op_a  = (t == 0) ? a : ~a;
            op_b  = (t == 0) ? b : ~b;
            ena   = (t == 0) || !(t >= sa && t < sa + sl);
            step();
            t++;
            if (busy) bc++;
            if (done) begin
                dn++;
                lat = t;
            end
        end
        start = 1'b0;
        ena   = 1'b1;
        repeat (2) begin
            step();
            if (busy) bc++;
            if (done) dn++;
        end
        r  = result;
        co = cout;
        ov = ovf;
    endtask

    task automatic run_and_check(input string tag, input logic s, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int sa, input int sl, input int ra);
        logic [W-1:0] er, gr;
        logic         eco, eov, gco, gov;
        int           lat, bc, dn;
        model(s, a, b, er, eco, eov);
        run_op(s, a, b, sa, sl, ra, gr, gco, gov, lat, bc, dn);
        check({tag, " result"},  32'(gr),  32'(er));
        check({tag, " cout"},    32'(gco), 32'(eco));
        check({tag, " ovf"},     32'(gov), 32'(eov));
        check({tag, " latency"}, lat,      LAT + sl);
        check({tag, " busy"},    bc,       LAT + sl);
        check({tag, " dones"},   dn,       1);
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        clr   = 1'b0;
        op_a  = '0;
        op_b  = '0;

        tbl[0] = '{1'b0, 16'h1234, 16'h0FCC, 16'h2200, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 16'h4321, 16'h4321, 16'h0000, 1'b1, 1'b0};

        #1;
        check("reset outputs", {busy, done, cout, ovf, result}, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        ena   = 1'b1;
        step();
        check("post-reset idle", {busy, done, cout, ovf, result}, 32'h0);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] gr;
            logic         gco, gov;
            int           lat, bc, dn;
            run_op(tbl[i].s, tbl[i].a, tbl[i].b, 99, 0, -1, gr, gco, gov, lat, bc, dn);
            check($sformatf("tbl%0d result", i), 32'(gr), 32'(tbl[i].r));
            check($sformatf("tbl%0d cout", i),   32'(gco), 32'(tbl[i].co));
            check($sformatf("tbl%0d ovf", i),    32'(gov), 32'(tbl[i].ov));
            check($sformatf("tbl%0d latency", i), lat, LAT);
            check($sformatf("tbl%0d busy", i),    bc, LAT);
            check($sformatf("tbl%0d dones", i),   dn, 1);
        end

        // Stray start during RUN is ignored
        run_and_check("restart", 1'b0, 16'h1234, 16'h0FCC, 99, 0, 2);
        // ena low for three cycles mid-RUN
        run_and_check("stall", 1'b0, 16'h1234, 16'h0FCC, 2, 3, -1);

        // done holds while ena is low
        sub = 1'b0; op_a = 16'h00F0; op_b = 16'h0010; start = 1'b1;
        step();
        start = 1'b0;
        repeat (LAT - 1) step();
        check("done visible", 32'(done), 32'd1);
        ena = 1'b0;
        repeat (2) step();
        check("done held ena low", {done, busy}, 32'h3);
        check("result held ena low", 32'(result), 32'h0100);
        ena = 1'b1;
        step();
        check("done dropped", {done, busy}, 32'h0);

        // clr at idx=2: abort, no done, partial result kept
        sub = 1'b0; op_a = 16'h1111; op_b = 16'h2222; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr idle", {busy, done}, 32'h0);
        check("clr result kept", 32'(result), 32'h0033);
        begin
            int dn;
            dn = 0;
            repeat (6) begin
                step();
                if (done || busy) dn++;
            end
            check("clr no done", dn, 0);
        end

        // Asynchronous reset mid-RUN
        sub = 1'b0; op_a = 16'hFFFF; op_b = 16'hFFFF; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        #1 rst_n = 1'b0;
        #1;
        check("async reset", {busy, done, cout, ovf, result}, 32'h0);
        #1 rst_n = 1'b1;
        run_and_check("after reset", 1'b1, 16'h0100, 16'h0101, 99, 0, -1);

        // Randomized operations with random stalls
        for (int i = 0; i < 40; i++) begin
            logic         s;
            logic [W-1:0] a, b;
            int           sa, sl;
            s  = 1'($urandom_range(0, 1));
            a  = W'($urandom);
            b  = W'($urandom);
            sa = $urandom_range(1, 4);
            sl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_and_check($sformatf("rand%0d", i), s, a, b, sa, sl, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
